uart_console_master: RTL
========================

UART_CONSOLE_MASTER -- requirements
Module: uart_console_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, AXI-lite base address of the UART register window.
REQ-002 SHALL have parameter POLL_GAP, default 16, idle cycles between consecutive status polls (1..255).
REQ-003 SHALL have port clock_i, input, 1, the single clock.
REQ-004 SHALL have port reset_ni, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port tx_data_i, input, 8, byte to transmit.
REQ-006 SHALL have port tx_valid_i, input, 1, tx byte offered.
REQ-007 SHALL have port tx_ready_o, output, 1, tx byte accepted when valid&ready.
REQ-008 SHALL have port rx_data_o, output, 8, received byte.
REQ-009 SHALL have port rx_valid_o, output, 1, rx byte held.
REQ-010 SHALL have port rx_ready_i, input, 1, consumer takes rx byte.
REQ-011 SHALL have port err_o, output, 1, sticky: any non-OKAY response seen.
REQ-012 SHALL have AXI-lite master bundle m_axilite_* (aw/w/b/ar/r channels, 32-bit addr/data, 4-bit strb, 3-bit prot) per the codebase master-port macro.

Function
REQ-013 SHALL use the UART register map: RXFIFO +0x0, TXFIFO +0x4, STAT +0x8 (bit0 rx_valid, bit3 tx_full), CTRL +0xC.
REQ-014 SHALL use FSM states INIT_W, INIT_B, IDLE, POLL_AR, POLL_R, RD_AR, RD_R, WR_AW, WR_B, GAP.
REQ-015 SHALL, after reset, enter INIT_W and write CTRL=0x3 (flush both FIFOs, interrupts off), then INIT_B waits for bvalid, then IDLE.
REQ-016 SHALL, from IDLE, go to POLL_AR unconditionally; POLL_AR holds arvalid with araddr=BASE+0x8 until arready.
REQ-017 SHALL, in POLL_R, hold rready=1; on rvalid latch STAT and decide in that cycle.
REQ-018 SHALL give RX priority: if STAT.bit0=1 and rx_valid_o=0 -> RD_AR; else if tx_valid_i=1 and STAT.bit3=0 -> WR_AW; else -> GAP.
REQ-019 SHALL, in RD_AR, issue read of BASE+0x0; in RD_R on rvalid load rdata[7:0] into rx_data_o, set rx_valid_o, -> GAP.
REQ-020 SHALL capture tx_data_i and pulse tx_ready_o for exactly one cycle on the POLL_R->WR_AW transition; tx_ready_o=0 at all other times.
REQ-021 SHALL, in WR_AW, assert awvalid and wvalid together (awaddr=BASE+0x4, wdata={24'h0,byte}, wstrb=4'h1); drop each independently on its ready; -> WR_B when both done.
REQ-022 SHALL, in WR_B, hold bready=1 and on bvalid -> GAP.
REQ-023 SHALL count POLL_GAP cycles in GAP, then -> IDLE; counter is 8 bits and reloads on each GAP entry.
REQ-024 SHALL clear rx_valid_o on rx_valid_o & rx_ready_i; a new RX read SHALL NOT start while rx_valid_o=1 (no byte loss).
REQ-025 SHALL set err_o on bresp or rresp != 2'b00; an erroring read still completes its state transition but SHALL NOT set rx_valid_o.
REQ-026 SHALL drive awprot=arprot=3'b000; at most one outstanding transaction at any time.
REQ-027 SHALL keep valid signals stable until handshake (AXI rule: no valid withdrawal).

Reset
REQ-028 SHALL, on reset_ni low, asynchronously force: state=INIT_W, all AXI valid/ready outputs 0, addresses/data 0, rx_valid_o=0, rx_data_o=0, tx_ready_o=0, err_o=0, gap counter 0.
REQ-029 SHALL abandon any transaction in flight on reset mid-operation; re-run init sequence after release.

Structure
REQ-030 SHALL place UART register offsets, STAT bit indices and the FSM state enum in uninasoc_pkg.
REQ-031 SHALL be a single module with no sub-modules; the AXI-lite bundle from uninasoc_axi.svh.

Verification
REQ-032 Reset release -> first transaction is AW/W to BASE+0xC data 0x3, then AR to BASE+0x8.
REQ-033 STAT=0x0, tx_valid_i=1 data 0x41 -> one tx_ready_o pulse, write BASE+0x4 wdata 0x00000041 wstrb 0x1.
REQ-034 STAT=0x8 (tx_full), tx_valid_i=1 -> no write, tx_ready_o stays 0, repoll after POLL_GAP cycles.
REQ-035 STAT=0x1 with tx_valid_i=1, RXFIFO=0x5A -> read occurs before write; rx_data_o=0x5A, rx_valid_o=1.
REQ-036 rx_ready_i=0 with rx_valid_o=1 and STAT=0x1 -> no RXFIFO read until consumed.
REQ-037 bresp=2'b10 on a TX write -> err_o=1 and remains 1 until reset; awready delayed 5 cycles vs wready -> single correct write.

Source files
------------

// File: rtl/uninasoc_pkg.sv
// Shared definitions for the UART console master: register map, STAT bits,
// AXI response helper and the console FSM state encoding.
package uninasoc_pkg;

  localparam logic [31:0] UART_RXFIFO_OFF = 32'h0000_0000;
  localparam logic [31:0] UART_TXFIFO_OFF = 32'h0000_0004;
  localparam logic [31:0] UART_STAT_OFF   = 32'h0000_0008;
  localparam logic [31:0] UART_CTRL_OFF   = 32'h0000_000C;

  localparam int unsigned UART_STAT_RX_VALID_BIT = 0;
  localparam int unsigned UART_STAT_TX_FULL_BIT  = 3;

  // Flush both FIFOs, leave interrupts disabled.
  localparam logic [31:0] UART_CTRL_INIT = 32'h0000_0003;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    INIT_W  = 4'd0,
    INIT_B  = 4'd1,
    IDLE    = 4'd2,
    POLL_AR = 4'd3,
    POLL_R  = 4'd4,
    RD_AR   = 4'd5,
    RD_R    = 4'd6,
    WR_AW   = 4'd7,
    WR_B    = 4'd8,
    GAP     = 4'd9
  } uart_cm_state_e;

  function automatic logic axi_resp_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/uart_console_master_if.sv
// AXI-lite bundle (aw/w/b/ar/r) between the console master and the UART slave.
interface uart_console_master_if;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/uart_console_master.sv
// Polls a memory-mapped UART over AXI-lite and bridges its FIFOs to simple
// valid/ready byte streams; RX is served before TX and one transaction is in flight.
module uart_console_master
  import uninasoc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          err_o,
  uart_console_master_if.master         m_axilite
);

  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);

  uart_cm_state_e state_q, state_d;
  logic [31:0]    awaddr_q, awaddr_d;
  logic           awvalid_q, awvalid_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic           wvalid_q, wvalid_d;
  logic           bready_q, bready_d;
  logic [31:0]    araddr_q, araddr_d;
  logic           arvalid_q, arvalid_d;
  logic           rready_q, rready_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           tx_ready_q, tx_ready_d;
  logic           err_q, err_d;
  logic [7:0]     gap_cnt_q, gap_cnt_d;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic aw_done_s, w_done_s;
  logic r_err_s, b_err_s;
  logic stat_rx_s, stat_txfull_s;
  logic unused_rdata_s;

  assign aw_hs_s       = awvalid_q & m_axilite.awready;
  assign w_hs_s        = wvalid_q & m_axilite.wready;
  assign b_hs_s        = bready_q & m_axilite.bvalid;
  assign ar_hs_s       = arvalid_q & m_axilite.arready;
  assign r_hs_s        = rready_q & m_axilite.rvalid;
  // AW and W complete independently; a channel stays done once its handshake happened.
  assign aw_done_s     = aw_done_q | aw_hs_s;
  assign w_done_s      = w_done_q | w_hs_s;
  assign r_err_s       = axi_resp_err(m_axilite.rresp);
  assign b_err_s       = axi_resp_err(m_axilite.bresp);
  assign stat_rx_s     = m_axilite.rdata[UART_STAT_RX_VALID_BIT];
  assign stat_txfull_s = m_axilite.rdata[UART_STAT_TX_FULL_BIT];
  assign unused_rdata_s = ^m_axilite.rdata[31:8];

  // Next-state and next-output logic of the console FSM.
  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    awvalid_d  = awvalid_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = 1'b0;
    err_d      = err_q;
    gap_cnt_d  = gap_cnt_q;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      INIT_W: begin
        awaddr_d  = BASE_ADDR + UART_CTRL_OFF;
        wdata_d   = UART_CTRL_INIT;
        wstrb_d   = 4'hF;
        awvalid_d = ~aw_done_s;
        wvalid_d  = ~w_done_s;
        if (aw_done_s && w_done_s) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = INIT_B;
        end else begin
          aw_done_d = aw_done_s;
          w_done_d  = w_done_s;
        end
      end

      INIT_B: begin
        if (b_hs_s) begin
          bready_d = 1'b0;
          err_d    = err_q | b_err_s;
          state_d  = IDLE;
        end else begin
          bready_d = 1'b1;
        end
      end

      IDLE: begin
        state_d = POLL_AR;
      end

      POLL_AR: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = POLL_R;
        end else begin
          arvalid_d = 1'b1;
          araddr_d  = BASE_ADDR + UART_STAT_OFF;
        end
      end

      POLL_R: begin
        if (r_hs_s) begin
          rready_d = 1'b0;
          // A failed STAT read carries no trustworthy status, so just back off.
          if (r_err_s) begin
            err_d     = 1'b1;
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end else if (stat_rx_s && !rx_valid_q) begin
            state_d = RD_AR;
          end else if (tx_valid_i && !stat_txfull_s) begin
            tx_ready_d = 1'b1;
            awaddr_d   = BASE_ADDR + UART_TXFIFO_OFF;
            wdata_d    = {24'h0, tx_data_i};
            wstrb_d    = 4'h1;
            state_d    = WR_AW;
          end else begin
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end
        end else begin
          rready_d = 1'b1;
        end
      end

      RD_AR: begin
        if (ar_hs_s) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end else begin
          arvalid_d = 1'b1;
          araddr_d  = BASE_ADDR + UART_RXFIFO_OFF;
        end
      end

      RD_R: begin
        if (r_hs_s) begin
          rready_d  = 1'b0;
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
          if (r_err_s) begin
            err_d = 1'b1;
          end else begin
            rx_data_d  = m_axilite.rdata[7:0];
            rx_valid_d = 1'b1;
          end
        end else begin
          rready_d = 1'b1;
        end
      end

      WR_AW: begin
        awvalid_d = ~aw_done_s;
        wvalid_d  = ~w_done_s;
        if (aw_done_s && w_done_s) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = WR_B;
        end else begin
          aw_done_d = aw_done_s;
          w_done_d  = w_done_s;
        end
      end

      WR_B: begin
        if (b_hs_s) begin
          bready_d  = 1'b0;
          err_d     = err_q | b_err_s;
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
        end else begin
          bready_d = 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = 8'd0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = INIT_W;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= INIT_W;
      awaddr_q   <= 32'h0;
      awvalid_q  <= 1'b0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      araddr_q   <= 32'h0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rx_data_q  <= 8'h0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      err_q      <= 1'b0;
      gap_cnt_q  <= 8'h0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      awvalid_q  <= awvalid_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      err_q      <= err_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign m_axilite.awaddr  = awaddr_q;
  assign m_axilite.awprot  = 3'b000;
  assign m_axilite.awvalid = awvalid_q;
  assign m_axilite.wdata   = wdata_q;
  assign m_axilite.wstrb   = wstrb_q;
  assign m_axilite.wvalid  = wvalid_q;
  assign m_axilite.bready  = bready_q;
  assign m_axilite.araddr  = araddr_q;
  assign m_axilite.arprot  = 3'b000;
  assign m_axilite.arvalid = arvalid_q;
  assign m_axilite.rready  = rready_q;

  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign err_o      = err_q;

endmodule
